// File: rtl/sw_led_pkg.sv
// sw_led_pkg: display mode encodings and default 100 MHz timing constants
package sw_led_pkg;
    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_RUN    = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;
    localparam int DEBOUNCE_10MS = 1_000_000;
    localparam int TICK_500MS    = 50_000_000;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchroniser plus hold-time debounce for one switch bit
module sw_debounce import sw_led_pkg::*; #(
    parameter int DEBOUNCE_CYC = DEBOUNCE_10MS
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_i,
    output logic db_o
);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);
    logic [1:0] sync_q;
    logic db_q, db_d, same, done;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        same  = sync_q[1] == db_q;
        done  = !same && cnt_q == LAST;
        db_d  = done ? sync_q[1] : db_q;
        cnt_d = (same || done) ? '0 : cnt_q + CW'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], sw_i};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end
    assign db_o = db_q;
endmodule

// File: rtl/sw_pattern_led.sv
// sw_pattern_led: debounced switch pattern compare driving LEDs in
// static, blink, running-light or match-count display modes
module sw_pattern_led import sw_led_pkg::*; #(
    parameter int N_SW         = 4,
    parameter int N_LED        = 16,
    parameter int DEBOUNCE_CYC = DEBOUNCE_10MS,
    parameter int BLINK_CYC    = TICK_500MS,
    parameter logic [N_SW-1:0] MATCH_PATTERN = N_SW'(4'b1000),
    parameter logic [N_SW-1:0] MATCH_MASK    = N_SW'(4'b1110)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SW-1:0]  sw,
    input  logic [1:0]       mode,
    output logic [N_SW-1:0]  sw_db,
    output logic             match,
    output logic [N_LED-1:0] led
);
    localparam int TW = $clog2(BLINK_CYC);
    localparam int PW = $clog2(N_LED);
    logic [N_SW-1:0]  db;
    mode_e            mode_q;
    logic             mode_chg, tick;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             match_q, match_d, mprev_q;
    logic             phase_q, phase_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [N_LED-1:0] cnt_q, cnt_d, led_q, led_d;
    for (genvar i = 0; i < N_SW; i++) begin : g_db
        sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk  (clk),
            .rst  (rst),
            .sw_i (sw[i]),
            .db_o (db[i])
        );
    end
    // A mode change restarts the display animation and suppresses that cycle's tick
    always_comb begin
        mode_chg = mode_e'(mode) != mode_q;
        tick     = !mode_chg && tcnt_q == TW'(BLINK_CYC - 1);
        tcnt_d   = (mode_chg || tick) ? '0 : tcnt_q + TW'(1);
        match_d  = ((db ^ MATCH_PATTERN) & MATCH_MASK) == '0;
        phase_d  = (mode_chg || !match_q) ? 1'b0 : phase_q ^ (tick && mode_q == MODE_BLINK);
        pos_d    = (mode_chg || !match_q) ? '0 :
                   (tick && mode_q == MODE_RUN) ? (pos_q == PW'(N_LED - 1) ? '0 : pos_q + PW'(1)) :
                   pos_q;
        cnt_d    = cnt_q + N_LED'(match_q && !mprev_q);
        led_d    = mode_q == MODE_STATIC ? N_LED'(match_q) :
                   mode_q == MODE_BLINK  ? N_LED'(match_q & phase_q) :
                   mode_q == MODE_RUN    ? (match_q ? N_LED'(1) << pos_q : '0) :
                   cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_STATIC;
            tcnt_q  <= '0;
            match_q <= 1'b0;
            mprev_q <= 1'b0;
            phase_q <= 1'b0;
            pos_q   <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_e'(mode);
            tcnt_q  <= tcnt_d;
            match_q <= match_d;
            mprev_q <= match_q;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end
    assign sw_db = db;
    assign match = match_q;
    assign led   = led_q;
endmodule
